// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Purpose:
//   N-road traffic-light sequencer. Only one road is green at a time. Each green
//   window is followed by a yellow phase and an all-red clearance phase. Vehicle
//   requests are latched into a pending vector and served round-robin, starting
//   from the road after the one last served. When no other road has demand, the
//   current road keeps green and the window restarts with no lamp change.
//   All lamp outputs are registered. There is no combinational path from the
//   inputs to the lamps.
//
// Optional feature (compile-time macro TLC_FLASH_EN):
//   When TLC_FLASH_EN is defined, i_flash_req forces a FLASH phase: every
//   yellow lamp blinks together and red and green are dark. When the request is
//   released, the sequencer runs a full all-red clearance and then resumes
//   round-robin service. Without the macro, i_flash_req is ignored and FLASH
//   cannot be reached.
//
// Ports:
//   i_clk        in   1          single clock, rising edge
//   i_rst_n      in   1          synchronous, active-low reset
//   i_enable     in   1          timing tick; low freezes state, counter and
//                                pending clears (requests still latch)
//   i_request    in   NUM_ROADS  per-road vehicle demand (level or pulse)
//   i_flash_req  in   1          flash request (used only with TLC_FLASH_EN)
//   o_red        out  NUM_ROADS  red lamps
//   o_yellow     out  NUM_ROADS  yellow lamps
//   o_green      out  NUM_ROADS  green lamps
//   o_phase      out  2          00 ALL_RED, 01 GREEN, 10 YELLOW, 11 FLASH
//   o_road       out  ROAD_W     current or last-served road
//   o_pending    out  NUM_ROADS  latched, not yet served requests
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
   parameter int unsigned NUM_ROADS      = 4,
   parameter int unsigned GREEN_CYCLES   = 20,
   parameter int unsigned YELLOW_CYCLES  = 4,
   parameter int unsigned ALL_RED_CYCLES = 2,
   parameter int unsigned FLASH_HALF     = 8,
   localparam int unsigned ROAD_W = ($clog2(NUM_ROADS) > 1) ? $clog2(NUM_ROADS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_enable,
   input  logic [NUM_ROADS-1:0] i_request,
   input  logic                 i_flash_req,
   output logic [NUM_ROADS-1:0] o_red,
   output logic [NUM_ROADS-1:0] o_yellow,
   output logic [NUM_ROADS-1:0] o_green,
   output logic [1:0]           o_phase,
   output logic [ROAD_W-1:0]    o_road,
   output logic [NUM_ROADS-1:0] o_pending
);

   // The flash half-period is included in the counter sizing in every build.
   // It is never larger than the green window at the default settings, so this
   // costs nothing there, and it keeps the counter width the same in both builds.
   localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES
                                                                    : YELLOW_CYCLES;
   localparam int unsigned MAX_GYR = (MAX_GY > ALL_RED_CYCLES) ? MAX_GY : ALL_RED_CYCLES;
   localparam int unsigned MAX_DUR = (MAX_GYR > FLASH_HALF) ? MAX_GYR : FLASH_HALF;
   localparam int unsigned CNT_W   = $clog2(MAX_DUR) + 1;

   localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
`ifdef TLC_FLASH_EN
   localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_HALF - 1);
`endif

   // The encoding is the o_phase value.
   typedef enum logic [1:0] {
      ST_ALL_RED = 2'b00,
      ST_GREEN   = 2'b01,
      ST_YELLOW  = 2'b10,
      ST_FLASH   = 2'b11
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [ROAD_W-1:0]    r_road;
   logic [NUM_ROADS-1:0] r_pending;
   logic [NUM_ROADS-1:0] r_red;
   logic [NUM_ROADS-1:0] r_yellow;
   logic [NUM_ROADS-1:0] r_green;

   logic [NUM_ROADS-1:0] w_road_oh;
   logic [NUM_ROADS-1:0] w_next_oh;
   logic [NUM_ROADS-1:0] w_req_mask;
   logic [NUM_ROADS-1:0] w_pending_nxt;
   logic [ROAD_W-1:0]    w_next_road;
   logic [ROAD_W-1:0]    w_idx;
   logic                 w_found;
   logic                 w_other_pending;
   logic                 w_flash_override;
   logic                 w_green_entry;

   assign w_road_oh       = NUM_ROADS'(1) << r_road;
   assign w_next_oh       = NUM_ROADS'(1) << w_next_road;
   assign w_other_pending = |(r_pending & ~w_road_oh);

   // Round-robin pick: the first pending road after r_road, wrapping around.
   // The search ends with r_road itself. With no demand it moves on to r_road + 1.
   always_comb begin
      w_found     = 1'b0;
      w_idx       = '0;
      w_next_road = ROAD_W'((32'(r_road) + 32'd1) % NUM_ROADS);
      for (int unsigned k = 1; k <= NUM_ROADS; k++) begin
         w_idx = ROAD_W'((32'(r_road) + k) % NUM_ROADS);
         if (!w_found && r_pending[w_idx]) begin
            w_found     = 1'b1;
            w_next_road = w_idx;
         end
      end
   end

`ifdef TLC_FLASH_EN
   // A flash request, or leaving flash, takes priority over normal sequencing.
   assign w_flash_override = i_flash_req | (r_state == ST_FLASH);
`else
   logic w_unused_flash;
   assign w_unused_flash   = i_flash_req;
   assign w_flash_override = 1'b0;
`endif

   // Demand for the road that is currently green is already being served, so it is not latched.
   assign w_req_mask    = i_request & ~((r_state == ST_GREEN) ? w_road_oh : '0);
   assign w_green_entry = i_enable && (r_state == ST_ALL_RED) && (r_cnt == '0) &&
                          !w_flash_override;
   // Clearing after the OR drops a request that arrives on the same edge the road turns green.
   assign w_pending_nxt = (r_pending | w_req_mask) & ~(w_green_entry ? w_next_oh : '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_ALL_RED;
         r_cnt     <= ALL_RED_LOAD;
         r_road    <= ROAD_W'(NUM_ROADS - 1);
         r_pending <= '0;
         r_red     <= '1;
         r_yellow  <= '0;
         r_green   <= '0;
      end else begin
         r_pending <= w_pending_nxt;
`ifdef TLC_FLASH_EN
         if (i_flash_req) begin
            if (r_state != ST_FLASH) begin
               // Enter flash on any edge. The flash starts with the yellow lamps on.
               r_state  <= ST_FLASH;
               r_cnt    <= FLASH_LOAD;
               r_red    <= '0;
               r_green  <= '0;
               r_yellow <= '1;
            end else if (i_enable) begin
               if (r_cnt == '0) begin
                  r_cnt    <= FLASH_LOAD;
                  r_yellow <= ~r_yellow;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
         end else if (r_state == ST_FLASH) begin
            // Leave flash through a full clearance. r_road is unchanged so that
            // round-robin service continues from the same road.
            r_state  <= ST_ALL_RED;
            r_cnt    <= ALL_RED_LOAD;
            r_red    <= '1;
            r_yellow <= '0;
            r_green  <= '0;
         end else
`endif
         if (i_enable) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_ONE;
            end else begin
               unique case (r_state)
                  ST_ALL_RED: begin
                     r_state  <= ST_GREEN;
                     r_cnt    <= GREEN_LOAD;
                     r_road   <= w_next_road;
                     r_green  <= w_next_oh;
                     r_red    <= ~w_next_oh;
                     r_yellow <= '0;
                  end
                  ST_GREEN: begin
                     if (w_other_pending) begin
                        r_state  <= ST_YELLOW;
                        r_cnt    <= YELLOW_LOAD;
                        r_yellow <= w_road_oh;
                        r_red    <= ~w_road_oh;
                        r_green  <= '0;
                     end else begin
                        // No competing demand: start a new window. The lamps do not change.
                        r_cnt <= GREEN_LOAD;
                     end
                  end
                  ST_YELLOW: begin
                     r_state  <= ST_ALL_RED;
                     r_cnt    <= ALL_RED_LOAD;
                     r_red    <= '1;
                     r_yellow <= '0;
                     r_green  <= '0;
                  end
                  ST_FLASH: begin
                     // Unreachable without flash support; recover to a safe clearance.
                     r_state  <= ST_ALL_RED;
                     r_cnt    <= ALL_RED_LOAD;
                     r_red    <= '1;
                     r_yellow <= '0;
                     r_green  <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign o_red     = r_red;
   assign o_yellow  = r_yellow;
   assign o_green   = r_green;
   assign o_phase   = r_state;
   assign o_road    = r_road;
   assign o_pending = r_pending;

   // Lamp safety checks: never two greens; outside flash each road shows exactly one lamp.
   a_one_green: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_green));

   a_one_lamp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (r_state != ST_FLASH) |->
         (((r_red | r_yellow | r_green) == '1) && ((r_red & r_yellow) == '0) &&
          ((r_red & r_green) == '0) && ((r_yellow & r_green) == '0)));

`ifndef TLC_FLASH_EN
   a_no_flash: assert property (@(posedge i_clk) disable iff (!i_rst_n) r_state != ST_FLASH);
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       flash;
   logic [3:0] red;
   logic [3:0] yellow;
   logic [3:0] green;
   logic [1:0] phase;
   logic [1:0] road;
   logic [3:0] pending;

   always #5 clk = ~clk;

   traffic_phase_sequencer #(
      .NUM_ROADS      (4),
      .GREEN_CYCLES   (20),
      .YELLOW_CYCLES  (4),
      .ALL_RED_CYCLES (2),
      .FLASH_HALF     (8)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (en),
      .i_request   (req),
      .i_flash_req (flash),
      .o_red       (red),
      .o_yellow    (yellow),
      .o_green     (green),
      .o_phase     (phase),
      .o_road      (road),
      .o_pending   (pending)
   );

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] yellow;
      logic [3:0] green;
      logic [1:0] phase;
      logic [1:0] road;
      logic [3:0] pending;
   } snap_t;

   snap_t exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    t        = 0;

   task automatic push(input string nm, input snap_t s);
      exp_q.push_back(s);
      name_q.push_back(nm);
   endtask

   // Builds the expected lamp pattern from the phase and the road.
   task automatic expect_st(input string nm, input logic [1:0] ph, input int rd,
                            input logic [3:0] pd);
      snap_t      s;
      logic [3:0] oh;
      oh        = 4'b0001 << rd;
      s.phase   = ph;
      s.road    = 2'(rd);
      s.pending = pd;
      s.red     = 4'b0000;
      s.yellow  = 4'b0000;
      s.green   = 4'b0000;
      case (ph)
         2'b00: s.red = 4'b1111;
         2'b01: begin s.green = oh; s.red = ~oh; end
         2'b10: begin s.yellow = oh; s.red = ~oh; end
         default: ;
      endcase
      push(nm, s);
   endtask

   task automatic expect_flash(input string nm, input logic on, input int rd,
                               input logic [3:0] pd);
      snap_t s;
      s.phase   = 2'b11;
      s.road    = 2'(rd);
      s.pending = pd;
      s.red     = 4'b0000;
      s.green   = 4'b0000;
      s.yellow  = on ? 4'b1111 : 4'b0000;
      push(nm, s);
   endtask

   // Inputs change 1 time unit after the rising edge, so the next edge samples them.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic goto(input int target);
      tick(target - t);
      t = target;
   endtask

   // Monitor: on each falling edge, check the invariants, then pop and compare
   // every expectation queued since the last rising edge.
   initial begin
      snap_t act;
      snap_t e;
      string nm;
      forever begin
         @(negedge clk);
         n_checks++;
         if ($countones(green) > 1) begin
            n_fail++;
            $display("FAIL one_green: got green=%b, required at most one bit set", green);
         end
`ifndef TLC_FLASH_EN
         n_checks++;
         if (phase == 2'b11) begin
            n_fail++;
            $display("FAIL no_flash_phase: got phase=%b, required phase other than 11", phase);
         end
`endif
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{red: red, yellow: yellow, green: green, phase: phase, road: road,
                    pending: pending};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got r=%b y=%b g=%b ph=%b road=%0d pend=%b, required r=%b y=%b g=%b ph=%b road=%0d pend=%b",
                        nm, act.red, act.yellow, act.green, act.phase, act.road, act.pending,
                        e.red, e.yellow, e.green, e.phase, e.road, e.pending);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 4'b0000;
      flash = 1'b0;

      // Reset is applied with enable low.
      tick(2);
      expect_st("reset", 2'b00, 3, 4'b0000);
      rst_n = 1'b1;
      en    = 1'b1;
      tick(1);
      expect_st("allred_after_rst", 2'b00, 3, 4'b0000);
      tick(1);
      expect_st("green0_rise", 2'b01, 0, 4'b0000);

      // g: edges counted from road-0 green entry. With no demand, green is held.
      t = 0;
      goto(21); expect_st("green0_win1_end", 2'b01, 0, 4'b0000);
      goto(22); expect_st("green0_held", 2'b01, 0, 4'b0000);
      goto(45);
      req = 4'b0100;
      goto(46); expect_st("req2_latched", 2'b01, 0, 4'b0100);
      req = 4'b0000;
      goto(59); expect_st("green0_last", 2'b01, 0, 4'b0100);
      goto(60); expect_st("yellow0_start", 2'b10, 0, 4'b0100);
      goto(63); expect_st("yellow0_last", 2'b10, 0, 4'b0100);
      goto(64); expect_st("allred_a0", 2'b00, 0, 4'b0100);
      goto(65); expect_st("allred_a1", 2'b00, 0, 4'b0100);
      goto(66); expect_st("green2", 2'b01, 2, 4'b0000);

      // h: edges counted from road-2 green entry. Serve road 1.
      t = 0;
      req = 4'b0010;
      goto(1); expect_st("req1_latched", 2'b01, 2, 4'b0010);
      req = 4'b0000;
      goto(26); expect_st("green1", 2'b01, 1, 4'b0000);

      // k: edges counted from road-1 green entry. Hold request 1010; road 1 is
      // masked while it is green, so service wraps to road 3 and then returns to road 1.
      t = 0;
      goto(2);
      req = 4'b1010;
      goto(3);  expect_st("req1_masked", 2'b01, 1, 4'b1000);
      goto(20); expect_st("yellow1", 2'b10, 1, 4'b1000);
      goto(21); expect_st("req1_after_green", 2'b10, 1, 4'b1010);
      goto(22);
      req = 4'b0000;
      goto(26); expect_st("green3_wrap", 2'b01, 3, 4'b0010);
      goto(46); expect_st("yellow3", 2'b10, 3, 4'b0010);
      goto(52); expect_st("green1_again", 2'b01, 1, 4'b0000);

      // m: edges counted from road-1 green entry. Stall in the middle of yellow.
      t = 0;
      req = 4'b0001;
      goto(1);
      req = 4'b0000;
      goto(20); expect_st("yellow1_b", 2'b10, 1, 4'b0001);
      goto(21);
      en = 1'b0;
      goto(24);
      req = 4'b0010;
      goto(25); expect_st("stall_req_latch", 2'b10, 1, 4'b0011);
      req = 4'b0000;
      goto(31); expect_st("stall_hold", 2'b10, 1, 4'b0011);
      en = 1'b1;
      goto(33); expect_st("yellow_14th", 2'b10, 1, 4'b0011);
      goto(34); expect_st("allred_after_stall", 2'b00, 1, 4'b0011);
      goto(36); expect_st("green0_after_stall", 2'b01, 0, 4'b0010);

      // n: edges counted from road-0 green entry. Reset is held for one edge mid-green.
      t = 0;
      goto(4);
      rst_n = 1'b0;
      goto(5); expect_st("rst_mid_green", 2'b00, 3, 4'b0000);
      rst_n = 1'b1;
      goto(6); expect_st("rst_allred", 2'b00, 3, 4'b0000);
      goto(7); expect_st("rst_green0", 2'b01, 0, 4'b0000);

`ifdef TLC_FLASH_EN
      // p: edges counted from road-0 green entry. Flash interrupts green.
      t = 0;
      goto(2);
      flash = 1'b1;
      goto(3);  expect_flash("flash_enter", 1'b1, 0, 4'b0000);
      goto(4);
      req = 4'b0100;
      goto(5);
      req = 4'b0000;
      goto(10); expect_flash("flash_on_last", 1'b1, 0, 4'b0100);
      goto(11); expect_flash("flash_off", 1'b0, 0, 4'b0100);
      goto(18); expect_flash("flash_off_last", 1'b0, 0, 4'b0100);
      goto(19); expect_flash("flash_on_again", 1'b1, 0, 4'b0100);
      flash = 1'b0;
      goto(20); expect_st("flash_exit", 2'b00, 0, 4'b0100);
      goto(21); expect_st("flash_exit_ar", 2'b00, 0, 4'b0100);
      goto(22); expect_st("flash_resume", 2'b01, 2, 4'b0000);
`else
      goto(12); expect_st("green0_tail", 2'b01, 0, 4'b0000);
`endif

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d unchecked entries, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised N-road traffic-light sequencer: one road green at a time, with programmable green, yellow and all-red durations. Vehicle requests are latched and served round-robin; a road with no competing demand holds green. Drives per-road red/yellow/green lamp vectors directly and replaces the fixed two-road state-to-lamp decode at the top of the intersection controller.

## Interface
- NUM_ROADS, 4, number of approaches (≥2)
- GREEN_CYCLES, 20, enabled cycles per green window (≥1)
- YELLOW_CYCLES, 4, enabled cycles of yellow (≥1)
- ALL_RED_CYCLES, 2, enabled cycles of all-red clearance (≥1)
- FLASH_HALF, 8, enabled cycles per flash half-period (≥1; used only with TLC_FLASH_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  timing tick; when low, counters and state freeze and outputs hold
- request  in  NUM_ROADS  per-road vehicle demand, level or pulse
- flash_req  in  1  fault/night flash request (ignored unless TLC_FLASH_EN)
- red  out  NUM_ROADS  red lamps
- yellow  out  NUM_ROADS  yellow lamps
- green  out  NUM_ROADS  green lamps
- phase  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 FLASH
- road  out  max(1,$clog2(NUM_ROADS))  index of current or last-served road
- pending  out  NUM_ROADS  latched unserved requests

## Operation
- States: ALL_RED, GREEN, YELLOW, FLASH. A down-counter (width $clog2 of largest duration + 1) is loaded with duration−1 on state entry. It decrements on each enabled cycle. The state exits on an enabled cycle where count==0.
- Lamps, all registered:
  - ALL_RED: red all ones.
  - GREEN: green[road]=1, red elsewhere.
  - YELLOW: yellow[road]=1, red elsewhere.
  - Exactly one lamp per road is lit outside FLASH.
- pending[i] is set on any cycle with request[i]=1, except while phase==GREEN and road==i. pending[road] is cleared on GREEN entry; a simultaneous request for that road is dropped.
- ALL_RED exit goes to GREEN. The next road is the first pending index searching road+1, road+2, … with wrap modulo NUM_ROADS. If nothing is pending, the next road is road+1 mod NUM_ROADS.
- GREEN expiry:
  - If any pending[j] with j≠road is set, go to YELLOW.
  - Otherwise reload GREEN_CYCLES−1 and hold green. No lamp glitch.
- YELLOW expiry goes to ALL_RED.
- Reset values: phase=00, road=NUM_ROADS−1, pending=0, red=all ones, yellow=0, green=0, counter=ALL_RED_CYCLES−1. Reset asserted mid-phase forces these values at the next edge, regardless of enable.

## Timing
- Outputs change only on clk rising edges; no combinational path from inputs to lamps.
- A request sampled at edge k is visible on pending after edge k.
- Each phase lasts exactly its duration in enabled cycles. With enable held high: GREEN→YELLOW→ALL_RED→next GREEN takes GREEN+YELLOW+ALL_RED cycles.
- After reset release, green[0] rises after the ALL_RED_CYCLES-th enabled edge.
- enable low: no state, counter or pending-clear change. Requests still latch.
- At most one green bit is set in any cycle. No road goes green→red without YELLOW, except on reset or flash entry.

## Configuration
- TLC_FLASH_EN defined:
  - flash_req=1 sampled on any edge enters FLASH on that edge, from any state. pending is kept.
  - In FLASH, red and green are 0 and yellow toggles all roads together every FLASH_HALF enabled cycles, starting on.
  - flash_req=0 on a FLASH edge goes to ALL_RED with a full ALL_RED_CYCLES; road is unchanged.
- TLC_FLASH_EN undefined: flash_req is unused, FLASH is unreachable, and phase never reads 11.

## Test plan
- Reset, then enable=1 with no requests → 2 cycles all-red, then green[0] for 20 cycles held in repeated windows; phase stays 01; no yellow.
- Raise request[2] for one cycle during road-0 green at cycle 5 → pending=0100, green[0] ends at cycle 20, 4 cycles yellow[0], 2 all-red, then green[2] with pending cleared.
- Set request=1010 during road-1 green → order is road 3 then road 1 (wrap past 3), each separated by yellow 4 + all-red 2.
- Drop enable for 10 cycles mid-yellow → yellow holds 14 cycles total; request[1] during the stall still latches.
- Assert rst_n=0 for one edge mid-green → next cycle red=1111, phase=00, pending=0; green[0] after 2 more edges.
- With TLC_FLASH_EN, flash_req=1 during green → next edge yellow=1111, toggling every 8 cycles. Deassert → 2 cycles all-red, then resume round-robin.
